// File: rtl/traffic_phase_arbiter.sv
// Round-robin, demand-driven phase scheduler for a four-approach intersection.
// Optional emergency preemption is compiled in with `define TRAFFIC_PREEMPT_EN.
module traffic_phase_arbiter #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] req,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
`endif
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights,
  output logic [3:0] grant,
  output logic [1:0] phase,
  output logic [3:0] pend
);

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);

  phase_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       pend_q;
  logic [1:0]       last_q;
  logic [1:0]       cur_q;

  logic       pre_act;
  logic [1:0] pre_dir;
`ifdef TRAFFIC_PREEMPT_EN
  assign pre_act = preempt;
  assign pre_dir = preempt_dir;
`else
  assign pre_act = 1'b0;
  assign pre_dir = 2'd0;
`endif

  logic [3:0] green_mask;
  logic       comp;
  logic       rr_found;
  logic [1:0] rr_sel;
  logic [1:0] rr_idx;
  logic       go_green;
  logic [1:0] go_dir;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;

  assign green_mask = 4'b0001 << cur_q;
  assign comp       = |(pend_q & ~green_mask);

  // Search last+1, last+2, ... so the most recently served approach goes last.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = last_q;
    rr_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_q + 2'(k);
      if (!rr_found && pend_q[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    go_green = (state_q == PH_ALL_RED) && (cnt_q == AR_LAST) && (pre_act || rr_found);
    go_dir   = pre_act ? pre_dir : rr_sel;
    set_mask = req & ~((state_q == PH_GREEN) ? green_mask : 4'b0000);
    clr_mask = go_green ? (4'b0001 << go_dir) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q <= PH_ALL_RED;
      cnt_q   <= '0;
      pend_q  <= 4'b0000;
      last_q  <= 2'd3;
      cur_q   <= 2'd0;
    end else begin
      // Clear wins over set when the approach enters green on this edge.
      pend_q <= (pend_q | set_mask) & ~clr_mask;
      case (state_q)
        PH_ALL_RED: begin
          if (go_green) begin
            state_q <= PH_GREEN;
            cur_q   <= go_dir;
            cnt_q   <= '0;
            if (!pre_act) last_q <= rr_sel;
          end else if (cnt_q != AR_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PH_GREEN: begin
          if (pre_act && (cur_q != pre_dir)) begin
            state_q <= PH_YELLOW;
            cnt_q   <= '0;
          end else if (!pre_act && comp && (cnt_q >= MIN_LAST) &&
                       (!req[cur_q] || (cnt_q == MAX_LAST))) begin
            state_q <= PH_YELLOW;
            cnt_q   <= '0;
          end else if (cnt_q != MAX_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PH_YELLOW: begin
          if (cnt_q == Y_LAST) begin
            state_q <= PH_ALL_RED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= PH_ALL_RED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  function automatic logic [2:0] light_of(input phase_t st, input logic sel);
    if (sel && st == PH_GREEN)  return 3'b001;
    if (sel && st == PH_YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  logic [3:0] active;
  assign active   = (state_q == PH_GREEN || state_q == PH_YELLOW) ? green_mask : 4'b0000;
  assign grant    = active;
  assign phase    = state_q;
  assign pend     = pend_q;
  assign n_lights = light_of(state_q, active[0]);
  assign s_lights = light_of(state_q, active[1]);
  assign e_lights = light_of(state_q, active[2]);
  assign w_lights = light_of(state_q, active[3]);

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter: driver pushes expected {phase,grant,pend}
// per edge into a queue; a monitor pops and compares one cycle at a time.
module tb_traffic_phase_arbiter;

  localparam logic [1:0] AR = 2'b00;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] YE = 2'b10;
  localparam int W = 10;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic [3:0] grant, pend;
  logic [1:0] phase;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_dir = 2'd0;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  traffic_phase_arbiter dut (
    .clk(clk), .rst_a(rst_a), .req(req),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt(preempt), .preempt_dir(preempt_dir),
`endif
    .n_lights(n_lights), .s_lights(s_lights), .e_lights(e_lights), .w_lights(w_lights),
    .grant(grant), .phase(phase), .pend(pend)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cycle, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_light(input logic [1:0] ph, input logic sel);
    if (sel && ph == GR) return 3'b001;
    if (sel && ph == YE) return 3'b010;
    return 3'b100;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [W-1:0] e;
    logic [1:0] eph;
    logic [3:0] egr, epd;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        {eph, egr, epd} = e;
        chk("phase", {2'b00, phase}, {2'b00, eph});
        chk("grant", grant, egr);
        chk("pend", pend, epd);
        chk("n_lights", {1'b0, n_lights}, {1'b0, exp_light(eph, egr[0])});
        chk("s_lights", {1'b0, s_lights}, {1'b0, exp_light(eph, egr[1])});
        chk("e_lights", {1'b0, e_lights}, {1'b0, exp_light(eph, egr[2])});
        chk("w_lights", {1'b0, w_lights}, {1'b0, exp_light(eph, egr[3])});
        chk("grant_onehot", {3'b000, ($countones(grant) > 1)}, 4'b0000);
      end
    end
  end

  // Driver: apply inputs for the next edge and queue the state expected after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic [1:0] ph,
                      input logic [3:0] gr, input logic [3:0] pd);
    rst_a = r;
    req   = rq;
    exp_q.push_back({ph, gr, pd});
    @(posedge clk);
    #2;
  endtask

  task automatic step_n(input int n, input logic [3:0] rq, input logic [1:0] ph,
                        input logic [3:0] gr, input logic [3:0] pd);
    for (int i = 0; i < n; i++) step(1'b0, rq, ph, gr, pd);
  endtask

  initial begin
    logic [3:0] pmask;
    @(posedge clk);
    #2;
    // Reset state, then N demand with no competition: green rests.
    step(1'b1, 4'b0000, AR, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, AR, 4'b0000, 4'b0000);
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0001);
    step(1'b0, 4'b0001, GR, 4'b0001, 4'b0000);
    step_n(50, 4'b0001, GR, 4'b0001, 4'b0000);
    // E pulse against saturated N green: immediate max-out, then E served.
    step(1'b0, 4'b0101, GR, 4'b0001, 4'b0100);
    step(1'b0, 4'b0001, YE, 4'b0001, 4'b0100);
    step_n(2, 4'b0001, YE, 4'b0001, 4'b0101);
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0101);
    step_n(4, 4'b0001, GR, 4'b0100, 4'b0001);
    step_n(3, 4'b0001, YE, 4'b0100, 4'b0001);
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0001);
    // Fresh N green with held req and S competing: max-out after 12 cycles.
    step(1'b0, 4'b0001, GR, 4'b0001, 4'b0000);
    step(1'b0, 4'b0011, GR, 4'b0001, 4'b0010);
    step_n(10, 4'b0001, GR, 4'b0001, 4'b0010);
    step(1'b0, 4'b0001, YE, 4'b0001, 4'b0010);
    step_n(2, 4'b0001, YE, 4'b0001, 4'b0011);
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0011);
    step(1'b0, 4'b0001, GR, 4'b0010, 4'b0001);
    step_n(3, 4'b0000, GR, 4'b0010, 4'b0001);
    step_n(2, 4'b0000, YE, 4'b0010, 4'b0001);
    // Reset during S yellow aborts straight to all-red.
    step(1'b1, 4'b0000, AR, 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, AR, 4'b0000, 4'b0000);
    // Gap-out held off until minimum green.
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0001);
    step(1'b0, 4'b0001, GR, 4'b0001, 4'b0000);
    step(1'b0, 4'b0010, GR, 4'b0001, 4'b0010);
    step_n(2, 4'b0000, GR, 4'b0001, 4'b0010);
    step_n(3, 4'b0000, YE, 4'b0001, 4'b0010);
    step(1'b0, 4'b0000, AR, 4'b0000, 4'b0010);
    step_n(2, 4'b0000, GR, 4'b0010, 4'b0000);
    // All four pending at once: N, S, E, W in order.
    step(1'b1, 4'b0000, AR, 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, AR, 4'b0000, 4'b1111);
    pmask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      pmask[i] = 1'b0;
      step_n((i == 3) ? 8 : 4, 4'b0000, GR, 4'b0001 << i, pmask);
      if (i < 3) begin
        step_n(3, 4'b0000, YE, 4'b0001 << i, pmask);
        step(1'b0, 4'b0000, AR, 4'b0000, pmask);
      end
    end
`ifdef TRAFFIC_PREEMPT_EN
    // Preempt to W from N green: yellow not shortened, W holds, then S resumes.
    step(1'b1, 4'b0000, AR, 4'b0000, 4'b0000);
    step(1'b0, 4'b0001, AR, 4'b0000, 4'b0001);
    step(1'b0, 4'b0001, GR, 4'b0001, 4'b0000);
    preempt = 1'b1;
    preempt_dir = 2'd3;
    step(1'b0, 4'b0010, YE, 4'b0001, 4'b0010);
    step_n(2, 4'b0000, YE, 4'b0001, 4'b0010);
    step(1'b0, 4'b0000, AR, 4'b0000, 4'b0010);
    step_n(6, 4'b0000, GR, 4'b1000, 4'b0010);
    preempt = 1'b0;
    step_n(3, 4'b0000, YE, 4'b1000, 4'b0010);
    step(1'b0, 4'b0000, AR, 4'b0000, 4'b0010);
    step(1'b0, 4'b0000, GR, 4'b0010, 4'b0000);
`endif
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain remaining=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout cycle=%0d expected=finish", cycle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
